conv_encoder: RTL
=================

Name: conv_encoder

Overview:
- Rate-1/2, constraint-length-4, 8-state convolutional encoder. It is the transmit-side partner of the team's Viterbi decoder.
- Accepts Z-bit data words through a valid/ready handshake.
- Emits one 2-bit code symbol per clock: Z data symbols, then TAIL zero-flush symbols, with the trellis cleared to state 0 at every frame start.
- Output symbols feed the decoder's 2-bit symbol input directly, one symbol per clock.

Parameters:
- Z, 8: data bits per frame.
- TAIL, 1: zero-input flush symbols appended per frame. Frame length F = Z+TAIL = 9 matches the decoder's N = Z+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  Z  frame payload; data_in[0] is encoded first.
- in_valid  in  1  payload valid.
- in_ready  out  1  encoder can accept a payload this cycle.
- sym_out  out  2  code symbol: bit1 = u^s2^s1^s0, bit0 = u^s2^s0.
- sym_valid  out  1  sym_out carries a symbol this cycle.
- frame_start  out  1  high with the first symbol of a frame.
- frame_end  out  1  high with the last (tail) symbol of a frame.
- underrun  out  1  one-cycle pulse when a frame ends with no payload pending.

Behaviour:
- Reset: in_ready=1, sym_out=0, sym_valid=0, frame_start=0, frame_end=0, underrun=0, state=IDLE, shift reg s[2:0]=0, pending buffer empty, counter=0.
- Shift register: next s = {u, s[2:1]}, where u is the current input bit (u goes to s2). This matches the decoder trellis (next = (u<<2)|(k>>1)). Generators are octal 17 (bit1) and 15 (bit0).
- Buffering:
  - One-entry pending buffer plus one working register.
  - in_ready = !pending_full.
  - Handshake completes when in_valid & in_ready on a rising edge.
  - While in_valid is high and in_ready low, data_in must be held stable.
- FSM states: IDLE, DATA, TAIL.
  - IDLE: if pending is full, or a handshake occurs this cycle, load the working register, clear s to 0 and the counter to 0, then go to DATA. The first symbol is registered onto sym_out the next cycle (latency 1 cycle from handshake). Input is bypassed straight into the working register when pending is empty.
  - DATA: each cycle encode u = work[cnt], sym_valid=1, frame_start=(cnt==0). After cnt==Z-1, go to TAIL; if TAIL==0, apply the TAIL end-of-frame rule instead.
  - TAIL: u=0, sym_valid=1, frame_end on the last tail symbol. At end of frame:
    - if a payload is pending (or handshaking this cycle), load it, clear s, and go to DATA. The next frame's first symbol follows the previous frame's last symbol with zero gap cycles.
    - otherwise pulse underrun and go to IDLE.
- sym_out holds its last value when sym_valid=0.
- Counter width: $clog2(F); no wrap beyond F-1.
- Simultaneous events:
  - A handshake in the last symbol cycle with pending empty loads directly into the working register.
  - With pending full, in_ready=0, so no handshake can occur.
- rst asserted mid-frame: the frame is abandoned and all state returns to its reset values on the next edge. No partial tail is emitted.

Optional Feature:
- Macro: CONV_ENC_ERR_INJ_EN.
- When defined:
  - Adds input err_mask[1:0].
  - sym_out = encoded symbol ^ err_mask, applied only when sym_valid=1.
  - Used to exercise the decoder's error correction.
- When undefined: no port, no XOR, and behaviour is identical to err_mask=0.

Decomposition:
- Package conv_code_pkg holds:
  - localparams K=4 and NUM_STATES=8;
  - generator constants G1=4'b1111 and G0=4'b1101;
  - the state enum {IDLE, DATA, TAIL};
  - function conv_sym(u, s) returning the 2-bit symbol, shared with the decoder-side BFM.
- Sub-module conv_enc_core: 3-bit shift register plus symbol XOR, with load_zero/advance controls.
- The FSM, buffers and counter live in the top level.

Test Plan:
- data_in=8'h01 → sym_out sequence 3,3,2,3,0,0,0,0,0. frame_start on the 1st symbol, frame_end on the 9th.
- data_in=8'hFF → 3,0,2,1,1,1,1,1, tail 2.
- data_in=8'h00 → nine symbols of 0 with sym_valid high for exactly 9 cycles, then underrun pulses once.
- Back-to-back 8'h01 and 8'hFF, second handshake during the first frame → 18 contiguous symbols with no gap. The second frame starts from s=0 (3,0,2,…); in_ready drops while pending is full.
- rst pulse at symbol 4 of a frame → next cycle all outputs are at reset values. A fresh 8'h01 then yields 3,3,2,3,… from the start.
- CONV_ENC_ERR_INJ_EN with err_mask=2'b01 on symbol 2 of 8'h01 → 3,2,2,3,0,0,0,0,0. The decoder then outputs the original payload bits.

Source files
------------

// File: rtl/conv_code_pkg.sv
// Shared constants, FSM state type and symbol function for the K=4 rate-1/2 convolutional code.
// Used by the encoder RTL and by the decoder-side bus-functional model.
package conv_code_pkg;

  localparam int unsigned K          = 4;
  localparam int unsigned NUM_STATES = 8;

  // Generators over {u, s2, s1, s0}: octal 17 drives bit1, octal 15 drives bit0.
  localparam logic [K-1:0] G1 = 4'b1111;
  localparam logic [K-1:0] G0 = 4'b1101;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StTail
  } enc_state_e;

  function automatic logic [1:0] conv_sym(input logic u, input logic [K-2:0] s);
    logic [K-1:0] taps;
    taps = {u, s};
    return {^(taps & G1), ^(taps & G0)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Trellis state register and symbol XOR of the convolutional encoder.
// load_zero_i clears the state for a new frame and takes priority over advance_i.
module conv_enc_core
  import conv_code_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_zero_i,
  input  logic       advance_i,
  input  logic       u_i,
  output logic [1:0] sym_o
);

  logic [K-2:0] s_q, s_d;

  // New bit enters at s2, matching the decoder trellis next = (u << 2) | (k >> 1).
  always_comb begin
    s_d = s_q;
    if (load_zero_i) begin
      s_d = '0;
    end else if (advance_i) begin
      s_d = {u_i, s_q[K-2:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign sym_o = conv_sym(u_i, s_q);

endmodule

// File: rtl/conv_encoder.sv
// Framed rate-1/2 convolutional encoder: Z data symbols plus TAIL flush symbols per payload.
// Optional CONV_ENC_ERR_INJ_EN adds err_mask, XORed into every valid output symbol.
module conv_encoder
  import conv_code_pkg::*;
#(
  parameter int unsigned Z    = 8,
  parameter int unsigned TAIL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [Z-1:0] data_in,
  input  logic         in_valid,
`ifdef CONV_ENC_ERR_INJ_EN
  input  logic [1:0]   err_mask,
`endif
  output logic         in_ready,
  output logic [1:0]   sym_out,
  output logic         sym_valid,
  output logic         frame_start,
  output logic         frame_end,
  output logic         underrun
);

  localparam int unsigned F    = Z + TAIL;
  localparam int unsigned CntW = (F > 1) ? $clog2(F) : 1;

  enc_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [Z-1:0] work_q, work_d;
  logic [Z-1:0] pend_q, pend_d;
  logic         pend_full_q, pend_full_d;
  logic [1:0]   sym_out_q, sym_out_d;
  logic         sym_valid_q, sym_valid_d;
  logic         frame_start_q, frame_start_d;
  logic         frame_end_q, frame_end_d;
  logic         underrun_q, underrun_d;

  logic         hs;
  logic         last_sym;
  logic         load_zero;
  logic         advance;
  logic         u;
  logic [1:0]   core_sym;
  logic [1:0]   err_v;

`ifdef CONV_ENC_ERR_INJ_EN
  assign err_v = err_mask;
`else
  assign err_v = 2'b00;
`endif

  assign in_ready = !pend_full_q;
  assign hs       = in_valid && in_ready;
  // Working word shifts right once per data symbol, so the next bit is always in bit 0.
  assign u        = (state_q == StData) ? work_q[0] : 1'b0;
  assign last_sym = (cnt_q == CntW'(F - 1));

  conv_enc_core u_core (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_zero_i(load_zero),
    .advance_i  (advance),
    .u_i        (u),
    .sym_o      (core_sym)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    work_d        = work_q;
    pend_d        = pend_q;
    pend_full_d   = pend_full_q;
    sym_out_d     = sym_out_q;
    sym_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    load_zero     = 1'b0;
    advance       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pend_full_q || hs) begin
          work_d      = pend_full_q ? pend_q : data_in;
          pend_full_d = 1'b0;
          load_zero   = 1'b1;
          cnt_d       = '0;
          state_d     = StData;
        end
      end
      StData, StTail: begin
        advance       = 1'b1;
        sym_valid_d   = 1'b1;
        sym_out_d     = core_sym ^ err_v;
        frame_start_d = (state_q == StData) && (cnt_q == '0);
        if (state_q == StData) begin
          work_d = work_q >> 1;
        end
        if (!last_sym) begin
          cnt_d = cnt_q + CntW'(1);
          if ((state_q == StData) && (cnt_q == CntW'(Z - 1))) begin
            state_d = StTail;
          end
          if (hs) begin
            pend_d      = data_in;
            pend_full_d = 1'b1;
          end
        end else begin
          // End of frame: a pending or concurrent payload starts the next frame with no gap.
          frame_end_d = 1'b1;
          if (pend_full_q || hs) begin
            work_d      = pend_full_q ? pend_q : data_in;
            pend_full_d = 1'b0;
            load_zero   = 1'b1;
            cnt_d       = '0;
            state_d     = StData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Underrun fires the cycle after a frame's last symbol if nothing followed it.
  assign underrun_d = frame_end_q && (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      work_q        <= '0;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      sym_out_q     <= 2'b00;
      sym_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      work_q        <= work_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      sym_out_q     <= sym_out_d;
      sym_valid_q   <= sym_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sym_out     = sym_out_q;
  assign sym_valid   = sym_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign underrun    = underrun_q;

endmodule
